vec_argbest_reduce: RTL and testbench
=====================================

Name: vec_argbest_reduce

Overview:
- Streaming reduction stage directly downstream of comparison_unit: consumes a vector of N elements over a valid/ready stream and returns the best value and its index.
- The "new element vs running best" decision is made by one comparison_unit instance. Its fn code selects max or min and which tie wins.
- Sits in the SIMD/vector datapath after operand fetch. Produces one result beat per vector for writeback.

Parameters:
- FUNCTION_BITS, 4, width of the fn code; same encoding as comparison_unit.
- BIT_WIDTH, 32, element and result data width.
- IDX_WIDTH, 16, width of the length and index fields.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a reduction; honoured only in IDLE.
- fn  input  FUNCTION_BITS  reduction mode; latched on an accepted start.
- len  input  IDX_WIDTH  element count N; latched on an accepted start.
- in_valid  input  1  element beat valid.
- in_ready  output  1  block can accept an element.
- in_data  input  BIT_WIDTH  element value (unsigned).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_value  output  BIT_WIDTH  best value.
- out_index  output  IDX_WIDTH  zero-based position of the best value.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. On reset:
  - state=IDLE.
  - in_ready, out_valid, busy = 0.
  - out_value, out_index, count, best registers = 0.
- Reset mid-vector: the partial result is discarded and no out_valid is produced. Beats still presented upstream are not accepted.
- States:
  - IDLE: in_ready=0. On start:
    - latch fn and len;
    - count←0;
    - go to FIRST if len≠0, else to DONE with out_value=0, out_index=0.
  - FIRST: in_ready=1. On in_valid&in_ready:
    - best←in_data, best_idx←0, count←1;
    - if len==1 go to DONE, else go to ACCUM.
  - ACCUM: in_ready=1. On each accepted beat:
    - comparison_unit evaluates data_in0=in_data against data_in1=best;
    - if its data_out[0]==1: best←in_data, best_idx←count;
    - count←count+1;
    - if count==len-1 (last beat): go to DONE. The result registers take the post-update best and best_idx in the same edge.
  - DONE: out_valid=1. out_value and out_index stay stable while out_valid is high. On out_ready: out_valid←0 and go to IDLE.
- fn meaning (unsigned compare):
  - 0010 gt: max, first occurrence wins ties.
  - 0011 gte: max, last occurrence wins.
  - 0100 lt: min, first occurrence.
  - 0101 lte: min, last occurrence.
  - Any other code (0000, 0001, 0110–1111): no replacement; result is element 0 with index 0. eq/neq are unsupported modes and not an error.
- Throughput and latency:
  - one element per cycle, no bubbles while in_valid is held high;
  - out_valid rises the cycle after the last beat is accepted;
  - back-to-back vectors need one IDLE cycle, where start is sampled.
- Input rules:
  - in_valid while in_ready=0 is ignored and the data is not consumed;
  - in_data is sampled only when in_valid&in_ready.
- start while busy is ignored; the latched fn and len do not change.
- start and out_ready on the same cycle in DONE: out_ready is honoured, start is ignored (the block is not yet IDLE).
- Widths:
  - count and best_idx are IDX_WIDTH;
  - maximum len is 2^IDX_WIDTH−1, so count never wraps;
  - the comparator is combinational, so the compare→update path is a single cycle.

Decomposition:
- Shared package vec_pkg:
  - FUNCTION_BITS, BIT_WIDTH, IDX_WIDTH defaults;
  - fn code constants CMP_EQ=0000, CMP_NEQ=0001, CMP_GT=0010, CMP_GTE=0011, CMP_LT=0100, CMP_LTE=0101;
  - state encoding IDLE, FIRST, ACCUM, DONE.
- Sub-module: one instance of the existing comparison_unit. No other sub-modules; the FSM, counter and best registers stay in this block.

Test Plan:
- fn=0010, len=5, data {3,9,2,9,7}, in_valid held high → out_valid 6 cycles after start; value=9, index=1.
- fn=0011, same data → value=9, index=3. fn=0101 on {4,1,6,1} → value=1, index=3. fn=0100 on {4,1,6,1} → value=1, index=1.
- Upstream bubbles (in_valid toggled 1,0,0,1,…) plus out_ready held low 4 cycles in DONE → result unchanged and out_valid stable until out_ready; start pulses while busy are ignored.
- Edge cases:
  - len=0 → DONE next cycle with value 0, index 0;
  - len=1, data 0xFFFFFFFF → value 0xFFFFFFFF, index 0;
  - fn=0001 on {5,8} → value 5, index 0.
- Reset asserted after 2 of 5 beats → next cycle in_ready=0, busy=0, out_valid=0. A new start with fn=0010, len=2, data {1,2} → value 2, index 1.
- Back-to-back: vector A then start in the first IDLE cycle for vector B → both results correct, exactly one out_valid handshake per vector.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants for the vector reduction datapath: default widths,
// comparison_unit fn codes and the argbest FSM state encoding.
package vec_pkg;

  localparam int unsigned DEF_FUNCTION_BITS = 4;
  localparam int unsigned DEF_BIT_WIDTH     = 32;
  localparam int unsigned DEF_IDX_WIDTH     = 16;

  localparam logic [DEF_FUNCTION_BITS-1:0] CMP_EQ  = 4'b0000;
  localparam logic [DEF_FUNCTION_BITS-1:0] CMP_NEQ = 4'b0001;
  localparam logic [DEF_FUNCTION_BITS-1:0] CMP_GT  = 4'b0010;
  localparam logic [DEF_FUNCTION_BITS-1:0] CMP_GTE = 4'b0011;
  localparam logic [DEF_FUNCTION_BITS-1:0] CMP_LT  = 4'b0100;
  localparam logic [DEF_FUNCTION_BITS-1:0] CMP_LTE = 4'b0101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/comparison_unit.sv
// Combinational unsigned comparator; data_out[0] is the result of
// data_in0 <op> data_in1 for the selected fn code, 0 for undefined codes.
module comparison_unit
  import vec_pkg::*;
#(
  parameter int unsigned FUNCTION_BITS = DEF_FUNCTION_BITS,
  parameter int unsigned BIT_WIDTH     = DEF_BIT_WIDTH
) (
  input  logic [FUNCTION_BITS-1:0] fn,
  input  logic [BIT_WIDTH-1:0]     data_in0,
  input  logic [BIT_WIDTH-1:0]     data_in1,
  output logic [0:0]               data_out
);

  always_comb begin
    data_out = 1'b0;
    case (fn)
      FUNCTION_BITS'(CMP_EQ):  data_out = data_in0 == data_in1;
      FUNCTION_BITS'(CMP_NEQ): data_out = data_in0 != data_in1;
      FUNCTION_BITS'(CMP_GT):  data_out = data_in0 >  data_in1;
      FUNCTION_BITS'(CMP_GTE): data_out = data_in0 >= data_in1;
      FUNCTION_BITS'(CMP_LT):  data_out = data_in0 <  data_in1;
      FUNCTION_BITS'(CMP_LTE): data_out = data_in0 <= data_in1;
      default:                 data_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/vec_argbest_reduce.sv
// Streaming arg-max/arg-min over an N-element vector; one element per cycle,
// one result beat per vector, replacement decided by comparison_unit.
module vec_argbest_reduce
  import vec_pkg::*;
#(
  parameter int unsigned FUNCTION_BITS = DEF_FUNCTION_BITS,
  parameter int unsigned BIT_WIDTH     = DEF_BIT_WIDTH,
  parameter int unsigned IDX_WIDTH     = DEF_IDX_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [FUNCTION_BITS-1:0] fn,
  input  logic [IDX_WIDTH-1:0]     len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIT_WIDTH-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_WIDTH-1:0]     out_value,
  output logic [IDX_WIDTH-1:0]     out_index,
  output logic                     busy
);

  state_t                   state, state_d;
  logic [FUNCTION_BITS-1:0] fn_q, fn_d;
  logic [IDX_WIDTH-1:0]     len_q, len_d;
  logic [IDX_WIDTH-1:0]     count, count_d;
  logic [IDX_WIDTH-1:0]     best_idx, best_idx_d;
  logic [BIT_WIDTH-1:0]     best, best_d;
  logic [BIT_WIDTH-1:0]     out_value_d;
  logic [IDX_WIDTH-1:0]     out_index_d;
  logic                     out_valid_d, in_ready_d, busy_d;
  logic [0:0]               cmp_hit;
  logic                     accept_c, supported_c, replace_c;

  comparison_unit #(
    .FUNCTION_BITS (FUNCTION_BITS),
    .BIT_WIDTH     (BIT_WIDTH)
  ) u_cmp (
    .fn       (fn_q),
    .data_in0 (in_data),
    .data_in1 (best),
    .data_out (cmp_hit)
  );

  assign accept_c = in_valid & in_ready;

  // eq/neq and undefined codes never replace, so element 0 wins.
  always_comb begin
    supported_c = 1'b0;
    case (fn_q)
      FUNCTION_BITS'(CMP_GT), FUNCTION_BITS'(CMP_GTE),
      FUNCTION_BITS'(CMP_LT), FUNCTION_BITS'(CMP_LTE): supported_c = 1'b1;
      default:                                         supported_c = 1'b0;
    endcase
    replace_c = supported_c & cmp_hit[0];
  end

  always_comb begin
    state_d     = state;
    fn_d        = fn_q;
    len_d       = len_q;
    count_d     = count;
    best_d      = best;
    best_idx_d  = best_idx;
    out_value_d = out_value;
    out_index_d = out_index;
    case (state)
      IDLE: begin
        if (start) begin
          fn_d    = fn;
          len_d   = len;
          count_d = '0;
          if (len != '0) begin
            state_d = FIRST;
          end else begin
            state_d     = DONE;
            out_value_d = '0;
            out_index_d = '0;
          end
        end
      end
      FIRST: begin
        if (accept_c) begin
          best_d     = in_data;
          best_idx_d = '0;
          count_d    = IDX_WIDTH'(1);
          if (len_q == IDX_WIDTH'(1)) begin
            state_d     = DONE;
            out_value_d = in_data;
            out_index_d = '0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept_c) begin
          if (replace_c) begin
            best_d     = in_data;
            best_idx_d = count;
          end
          count_d = count + IDX_WIDTH'(1);
          // Result registers capture the post-update best on the last beat.
          if (count == len_q - IDX_WIDTH'(1)) begin
            state_d     = DONE;
            out_value_d = best_d;
            out_index_d = best_idx_d;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == FIRST) || (state_d == ACCUM);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fn_q      <= '0;
      len_q     <= '0;
      count     <= '0;
      best      <= '0;
      best_idx  <= '0;
      out_value <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      fn_q      <= fn_d;
      len_q     <= len_d;
      count     <= count_d;
      best      <= best_d;
      best_idx  <= best_idx_d;
      out_value <= out_value_d;
      out_index <= out_index_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_vec_argbest_reduce.sv
// Scoreboard bench for vec_argbest_reduce: directed spec cases plus random
// vectors, checked against a find-extreme-then-locate reference model.
module tb_vec_argbest_reduce;

  localparam int unsigned FB = 4;
  localparam int unsigned BW = 32;
  localparam int unsigned IW = 16;

  typedef struct {
    logic [BW-1:0] value;
    logic [IW-1:0] index;
    int            lat;
    int            t0;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [FB-1:0] fn = '0;
  logic [IW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_value;
  logic [IW-1:0] out_index;
  logic          busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   force_low = 1'b0;
  exp_t sb[$];

  vec_argbest_reduce dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .fn        (fn),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_index (out_index),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: find the extreme value, then locate its first or last position.
  function automatic void model(input logic [FB-1:0] f, input logic [BW-1:0] d[$],
                                output logic [BW-1:0] v, output logic [IW-1:0] ix);
    logic [BW-1:0] ext;
    bit            is_max, last_wins;
    v = '0; ix = '0;
    if (d.size() == 0) return;
    case (f)
      4'b0010: begin is_max = 1; last_wins = 0; end
      4'b0011: begin is_max = 1; last_wins = 1; end
      4'b0100: begin is_max = 0; last_wins = 0; end
      4'b0101: begin is_max = 0; last_wins = 1; end
      default: begin v = d[0]; ix = '0; return; end
    endcase
    ext = d[0];
    foreach (d[i]) if (is_max ? (d[i] > ext) : (d[i] < ext)) ext = d[i];
    v = ext;
    ix = '1;
    foreach (d[i]) if (d[i] == ext && (last_wins || ix == '1)) ix = IW'(i);
  endfunction

  // Random consumer backpressure, overridable for the hold test.
  always @(posedge clk) begin
    #2;
    out_ready = force_low ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // Monitor: result, latency and stability checks.
  bit            prev_valid = 0, prev_hs = 0;
  logic [BW-1:0] prev_val;
  logic [IW-1:0] prev_idx;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 0;
      prev_hs = 0;
    end else begin
      if (out_valid && !prev_valid && sb.size() > 0 && sb[0].lat >= 0)
        chk("latency", 64'(cyc - sb[0].t0), 64'(sb[0].lat));
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_value", 64'(out_value), 64'(prev_val));
        chk("hold_index", 64'(out_index), 64'(prev_idx));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_value", 64'(out_value), 64'(e.value));
          chk("out_index", 64'(out_index), 64'(e.index));
        end
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_val   = out_value;
      prev_idx   = out_index;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_beat(input logic [BW-1:0] v);
    bit acc = 0;
    int w = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!acc) begin
      acc = in_ready;
      step();
      w++;
      if (!acc && w > 50) begin
        chk("beat_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input logic [FB-1:0] f, input logic [BW-1:0] d[$],
                            input bit bubbles, input bit hold);
    exp_t e;
    int   w;
    model(f, d, e.value, e.index);
    e.lat = bubbles ? -1 : d.size() + 1;
    e.t0  = cyc;
    sb.push_back(e);
    if (hold) force_low = 1'b1;
    start = 1'b1; fn = f; len = IW'(d.size());
    step();
    start = 1'b0;
    foreach (d[i]) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          start    = 1'($urandom_range(0, 1));
          fn       = FB'($urandom);
          len      = IW'($urandom);
          step();
          start = 1'b0;
        end
      end
      feed_beat(d[i]);
    end
    if (hold) begin
      w = 0;
      while (!out_valid && w < 50) begin step(); w++; end
      chk("hold_reached_done", 64'(out_valid), 64'd1);
      repeat (4) begin
        start = 1'b1; fn = 4'b0011; len = 16'd7;
        step();
      end
      start = 1'b0;
      chk("valid_after_hold", 64'(out_valid), 64'd1);
      force_low = 1'b0;
    end
    w = 0;
    while (busy && w < 200) begin step(); w++; end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] d[$];
    logic [FB-1:0] rf;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_value", 64'(out_value), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);

    d = '{32'd3, 32'd9, 32'd2, 32'd9, 32'd7};
    run_vector(4'b0010, d, 0, 0);
    run_vector(4'b0011, d, 0, 0);
    run_vector(4'b0010, d, 1, 1);
    d = '{32'd4, 32'd1, 32'd6, 32'd1};
    run_vector(4'b0101, d, 0, 0);
    run_vector(4'b0100, d, 0, 0);
    d = {};
    run_vector(4'b0010, d, 0, 0);
    d = '{32'hFFFF_FFFF};
    run_vector(4'b0010, d, 0, 0);
    d = '{32'd5, 32'd8};
    run_vector(4'b0001, d, 0, 0);

    // Abort a vector mid-stream with reset; no result may appear.
    start = 1'b1; fn = 4'b0010; len = 16'd5;
    step();
    start = 1'b0;
    feed_beat(32'd10);
    feed_beat(32'd20);
    in_valid = 1'b1; in_data = 32'd99;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    step();
    chk("abort_idle_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    d = '{32'd1, 32'd2};
    run_vector(4'b0010, d, 0, 0);

    // Random back-to-back vectors with ties, bubbles and mixed fn codes.
    for (int v = 0; v < 40; v++) begin
      d = {};
      for (int i = 0; i < int'($urandom_range(0, 12)); i++)
        d.push_back(($urandom_range(0, 1) != 0) ? BW'($urandom_range(0, 7)) : BW'($urandom));
      rf = ($urandom_range(0, 4) == 0) ? FB'($urandom) : FB'($urandom_range(2, 5));
      run_vector(rf, d, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 5) == 0));
    end

    repeat (5) step();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
